// File: rtl/control_pkg.sv
// control_pkg: control word layout, state and pc_fs codes, decoder classes and opcode prefix table
package control_pkg;
    typedef struct packed {
        logic       alu_en;
        logic       alu_bsel;
        logic [4:0] alu_fs;
        logic       rf_b_en;
        logic [4:0] sa;
        logic [4:0] sb;
        logic [4:0] da;
        logic       rf_wr;
        logic       ram_en;
        logic       ram_wr;
        logic       pc_en;
        logic [1:0] pc_fs;
        logic       pc_insel;
        logic       status_ld;
        logic [1:0] next_state;
    } cw_t;
    localparam int CW_WIDTH = $bits(cw_t);
    typedef enum logic [1:0] {PC_HOLD = 2'b00, PC_INC = 2'b01, PC_BR = 2'b11} pc_fs_t;
    typedef enum logic [1:0] {ST_FETCH = 2'b00, ST_EX0 = 2'b01, ST_EX1 = 2'b10, ST_EX2 = 2'b11} state_t;
    localparam cw_t FETCH_CW = 33'h111;
    typedef enum logic [2:0] {
        DS_R = 3'd0, DS_I = 3'd1, DS_D = 3'd2, DS_B = 3'd3, DS_CB = 3'd4, DS_IW = 3'd5, DS_ILLEGAL = 3'd7
    } dsel_t;
    typedef struct packed {
        logic [10:0] pat;
        logic [10:0] mask;
        dsel_t       cls;
    } op_entry_t;
    localparam int N_OPS = 21;
    // Patterns are left-aligned on IR[31:21]; entries are ordered longest prefix first.
    localparam op_entry_t OP_TABLE [N_OPS] = '{
        '{11'h458, 11'h7FF, DS_R},
        '{11'h658, 11'h7FF, DS_R},
        '{11'h450, 11'h7FF, DS_R},
        '{11'h550, 11'h7FF, DS_R},
        '{11'h650, 11'h7FF, DS_R},
        '{11'h69B, 11'h7FF, DS_R},
        '{11'h69A, 11'h7FF, DS_R},
        '{11'h7C2, 11'h7FF, DS_D},
        '{11'h7C0, 11'h7FF, DS_D},
        '{11'h488, 11'h7FE, DS_I},
        '{11'h688, 11'h7FE, DS_I},
        '{11'h490, 11'h7FE, DS_I},
        '{11'h590, 11'h7FE, DS_I},
        '{11'h690, 11'h7FE, DS_I},
        '{11'h694, 11'h7FC, DS_IW},
        '{11'h794, 11'h7FC, DS_IW},
        '{11'h5A0, 11'h7F8, DS_CB},
        '{11'h5A8, 11'h7F8, DS_CB},
        '{11'h2A0, 11'h7F8, DS_CB},
        '{11'h0A0, 11'h7E0, DS_B},
        '{11'h4A0, 11'h7E0, DS_B}
    };
endpackage

// File: rtl/opcode_classifier.sv
// opcode_classifier: longest-prefix match of IR[31:21] against the opcode table, no match gives ILLEGAL
module opcode_classifier
    import control_pkg::*;
(
    input  logic [10:0] opcode,
    output dsel_t       decoder_select
);
    always_comb begin
        decoder_select = DS_ILLEGAL;
        for (int i = N_OPS - 1; i >= 0; i--)
            if ((opcode & OP_TABLE[i].mask) == OP_TABLE[i].pat) decoder_select = OP_TABLE[i].cls;
    end
endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: IR/state/status registers, decoder selection, fetch word and stall gating of the control word
module control_sequencer
    import control_pkg::*;
#(
    parameter int INSTR_WIDTH = 32,
    parameter int DATA_WIDTH  = 64
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   mem_wait,
    input  logic [DATA_WIDTH-1:0]  databus_in,
    input  logic [4:0]             status_in,
    input  logic [CW_WIDTH-1:0]    decoder_controlword,
    input  logic [DATA_WIDTH-1:0]  decoder_constant,
    output logic [INSTR_WIDTH-1:0] instruction,
    output logic [1:0]             state,
    output logic [4:0]             status,
    output logic [2:0]             decoder_select,
    output logic [CW_WIDTH-1:0]    controlword,
    output logic [DATA_WIDTH-1:0]  constant,
    output logic                   illegal_opcode
);
    state_t st;
    dsel_t  dsel;
    cw_t    raw_cw;
    cw_t    out_cw;
    logic   exec;
    logic   unused_bus;
    assign unused_bus = ^databus_in[DATA_WIDTH-1:INSTR_WIDTH];
    opcode_classifier u_classifier (
        .opcode         (instruction[INSTR_WIDTH-1 -: 11]),
        .decoder_select (dsel)
    );
    assign exec           = st != ST_FETCH;
    assign state          = st;
    assign decoder_select = dsel;
    assign controlword    = out_cw;
    assign constant       = exec ? decoder_constant : '0;
    // An illegal opcode in execute becomes a NOP whose next_state 00 returns to fetch.
    always_comb begin
        raw_cw = !exec ? FETCH_CW : dsel == DS_ILLEGAL ? cw_t'('0) : cw_t'(decoder_controlword);
        out_cw = raw_cw;
        if (mem_wait) begin
            out_cw.pc_fs     = PC_HOLD;
            out_cw.rf_wr     = 1'b0;
            out_cw.ram_wr    = 1'b0;
            out_cw.status_ld = 1'b0;
        end
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            st             <= ST_FETCH;
            instruction    <= '0;
            status         <= '0;
            illegal_opcode <= 1'b0;
        end else if (!mem_wait) begin
            st <= state_t'(raw_cw.next_state);
            if (!exec) instruction <= databus_in[INSTR_WIDTH-1:0];
            if (raw_cw.status_ld) status <= status_in;
            if (exec && dsel == DS_ILLEGAL) illegal_opcode <= 1'b1;
        end
    end
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: directed vectors with hand-computed expectations for control_sequencer
module tb_control_sequencer;
    logic        clock = 1'b0;
    logic        reset;
    logic        mem_wait;
    logic [63:0] databus_in;
    logic [4:0]  status_in;
    logic [32:0] decoder_controlword;
    logic [63:0] decoder_constant;
    logic [31:0] instruction;
    logic [1:0]  state;
    logic [4:0]  status;
    logic [2:0]  decoder_select;
    logic [32:0] controlword;
    logic [63:0] constant;
    logic        illegal_opcode;
    int          errors = 0;
    int          checks = 0;
    control_sequencer dut (
        .clock               (clock),
        .reset               (reset),
        .mem_wait            (mem_wait),
        .databus_in          (databus_in),
        .status_in           (status_in),
        .decoder_controlword (decoder_controlword),
        .decoder_constant    (decoder_constant),
        .instruction         (instruction),
        .state               (state),
        .status              (status),
        .decoder_select      (decoder_select),
        .controlword         (controlword),
        .constant            (constant),
        .illegal_opcode      (illegal_opcode)
    );
    always #5 clock = ~clock;
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clock);
        #1;
    endtask
    logic [31:0] cls_instr [6] = '{32'hF8400000, 32'hB4000000, 32'hD2800000, 32'hD2000000, 32'hD3400000, 32'h54000000};
    logic [2:0]  cls_exp   [6] = '{3'd2, 3'd4, 3'd5, 3'd1, 3'd0, 3'd4};
    initial begin
        reset = 1'b1;
        mem_wait = 1'b0;
        databus_in = 64'hFFFF_FFFF_0000_0000;
        status_in = 5'b0;
        decoder_controlword = '0;
        decoder_constant = 64'h1234;
        tick();
        reset = 1'b0;
        check("rst_state", 64'(state), 64'd0);
        check("rst_instr", 64'(instruction), 64'd0);
        check("rst_status", 64'(status), 64'd0);
        check("rst_illegal", 64'(illegal_opcode), 64'd0);
        databus_in = 64'hABCD_0000_1400_0010;
        #1;
        check("fetch_cw", 64'(controlword), 64'h111);
        check("fetch_const", constant, 64'd0);
        tick();
        check("t1_instr", 64'(instruction), 64'h14000010);
        check("t1_state", 64'(state), 64'd1);
        check("t1_dsel", 64'(decoder_select), 64'd3);
        decoder_controlword = 33'h78;
        #1;
        check("t2_cw", 64'(controlword), 64'h78);
        check("t2_const", constant, 64'h1234);
        tick();
        check("t2_state", 64'(state), 64'd0);
        mem_wait = 1'b1;
        databus_in = 64'h8B00_0000;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t3_stall_cw", 64'(controlword), 64'h101);
            tick();
            check("t3_stall_state", 64'(state), 64'd0);
            check("t3_stall_instr", 64'(instruction), 64'h14000010);
        end
        mem_wait = 1'b0;
        tick();
        check("t3_instr", 64'(instruction), 64'h8B000000);
        check("t3_state", 64'(state), 64'd1);
        check("t3_dsel_r", 64'(decoder_select), 64'd0);
        decoder_controlword = 33'h5;
        status_in = 5'b10110;
        tick();
        check("t4_status_ld", 64'(status), 64'b10110);
        check("t4_state", 64'(state), 64'd1);
        decoder_controlword = 33'h1;
        status_in = 5'b01001;
        tick();
        check("t4_no_ld", 64'(status), 64'b10110);
        decoder_controlword = 33'h5;
        mem_wait = 1'b1;
        #1;
        check("t4_stall_cw", 64'(controlword), 64'h1);
        tick();
        check("t4_stall_status", 64'(status), 64'b10110);
        check("t4_stall_state", 64'(state), 64'd1);
        decoder_controlword = 33'h1_FFFF_FFFF;
        #1;
        check("stall_mask", 64'(controlword), 64'h1_FFFF_FD4B);
        mem_wait = 1'b0;
        decoder_controlword = '0;
        tick();
        check("back_fetch", 64'(state), 64'd0);
        foreach (cls_instr[i]) begin
            databus_in = {32'h0, cls_instr[i]};
            tick();
            check("class_dsel", 64'(decoder_select), 64'(cls_exp[i]));
            tick();
        end
        check("no_illegal_yet", 64'(illegal_opcode), 64'd0);
        databus_in = 64'h0;
        tick();
        check("t5_dsel", 64'(decoder_select), 64'd7);
        decoder_controlword = 33'h1_FFFF_FFFF;
        #1;
        check("t5_cw_nop", 64'(controlword), 64'd0);
        check("t5_illegal_pre", 64'(illegal_opcode), 64'd0);
        tick();
        check("t5_state", 64'(state), 64'd0);
        check("t5_illegal", 64'(illegal_opcode), 64'd1);
        decoder_controlword = '0;
        databus_in = 64'h9100_0000;
        tick();
        check("t5_dsel_i", 64'(decoder_select), 64'd1);
        tick();
        check("t5_sticky", 64'(illegal_opcode), 64'd1);
        databus_in = 64'h1400_0010;
        tick();
        decoder_controlword = 33'h2;
        tick();
        check("t6_state_ex1", 64'(state), 64'd2);
        decoder_controlword = 33'h205;
        status_in = 5'b11111;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t6_state", 64'(state), 64'd0);
        check("t6_instr", 64'(instruction), 64'd0);
        check("t6_illegal", 64'(illegal_opcode), 64'd0);
        check("t6_status", 64'(status), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
